// File: rtl/ftq_redirect_ctrl_pkg.sv
// Shared frontend redirect types: FTQ geometry, redirect source/class,
// redirect request bundle and the redirect sequencer state encoding.
// Pure declarations, no logic; imported by the redirect controller and its bench.
package ftq_redirect_ctrl_pkg;

    // FTQ geometry as seen by the whole frontend (core_config side).
    localparam int FRONTEND_FTQ_SIZE   = 8;
    localparam int FRONTEND_PTR_W      = $clog2(FRONTEND_FTQ_SIZE);
    localparam int FRONTEND_ADDR_WIDTH = 32;

    // Which requester produced the surviving flush; selects the FTQ flush class.
    typedef enum logic {
        SRC_BACKEND = 1'b0,
        SRC_IFU     = 1'b1
    } redirect_src_e;

    // One redirect request as presented by a flush source.
    typedef struct packed {
        logic                           valid;
        logic [FRONTEND_PTR_W-1:0]      ftq_id;
        logic [FRONTEND_ADDR_WIDTH-1:0] target;
    } ftq_redirect_req_t;

    // Redirect sequencer: waiting, issuing the flush pulse, refilling.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } redirect_state_e;

endpackage : ftq_redirect_ctrl_pkg

// File: rtl/ftq_age_compare.sv
// Purpose: decide which of two FTQ ids is older relative to the commit pointer.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, result is valid whenever inputs are.
//
// Ports:
//   comm_ptr_i   : FTQ commit pointer, the age base
//   id_a_i       : first FTQ id (wins ties)
//   id_b_i       : second FTQ id
//   older_is_a_o : 1 when id_a_i is older than or as old as id_b_i
module ftq_age_compare #(
    parameter int PTR_W = 3
) (
    input  logic [PTR_W-1:0] comm_ptr_i,
    input  logic [PTR_W-1:0] id_a_i,
    input  logic [PTR_W-1:0] id_b_i,
    output logic             older_is_a_o
);

    logic [PTR_W-1:0] age_a;
    logic [PTR_W-1:0] age_b;

    // Subtraction at PTR_W bits wraps modulo the (power-of-two) FTQ size,
    // so an id just behind the commit pointer reads as the youngest entry.
    assign age_a = id_a_i - comm_ptr_i;
    assign age_b = id_b_i - comm_ptr_i;

    // Equal age means the same FTQ entry; a is preferred so callers can put
    // the authoritative source on port a.
    assign older_is_a_o = (age_a <= age_b);

endmodule : ftq_age_compare

// File: rtl/ftq_redirect_ctrl.sv
// Purpose: arbitrate backend/IFU redirects by FTQ age, pulse one flush to FTQ+BPU, then stall the frontend.
// Latency: request accepted in cycle N produces the flush pulse in N+1; stall spans 1+RECOVER_CYCLES cycles.
// Backpressure: none accepted from requesters; losing or late IFU requests are dropped, backend preempts.
//
// Optional build macro FTQ_REDIRECT_PERF_EN adds four saturating 32-bit
// performance counters (backend pulses, IFU pulses, IFU drops, stall cycles).
//
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   comm_ptr_i                 : FTQ commit pointer (age base)
//   backend_flush_*_i          : backend redirect request (valid, FTQ id, target PC)
//   ifu_flush_*_i              : IFU predecoder redirect request (valid, FTQ id, target PC)
//   ftq_backend_flush_o        : one-cycle backend-class flush pulse to FTQ
//   ftq_ifu_flush_o            : one-cycle IFU-class flush pulse to FTQ
//   ftq_flush_ftq_id_o         : FTQ id of the latched flush
//   bpu_redirect_valid_o       : one-cycle BPU redirect
//   bpu_redirect_pc_o          : redirect PC of the latched flush
//   frontend_stall_o           : holds BPU P0 / IFU accept during flush and recovery
//   busy_o                     : sequencer not idle
//   perf_*_o (macro only)      : saturating event counters
module ftq_redirect_ctrl
    import ftq_redirect_ctrl_pkg::*;
#(
    parameter int FTQ_SIZE       = FRONTEND_FTQ_SIZE,
    parameter int ADDR_WIDTH     = FRONTEND_ADDR_WIDTH,
    parameter int RECOVER_CYCLES = 2,
    localparam int PTR_W         = $clog2(FTQ_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PTR_W-1:0]      comm_ptr_i,
    input  logic                  backend_flush_valid_i,
    input  logic [PTR_W-1:0]      backend_flush_ftq_id_i,
    input  logic [ADDR_WIDTH-1:0] backend_flush_target_i,
    input  logic                  ifu_flush_valid_i,
    input  logic [PTR_W-1:0]      ifu_flush_ftq_id_i,
    input  logic [ADDR_WIDTH-1:0] ifu_flush_target_i,
    output logic                  ftq_backend_flush_o,
    output logic                  ftq_ifu_flush_o,
    output logic [PTR_W-1:0]      ftq_flush_ftq_id_o,
    output logic                  bpu_redirect_valid_o,
    output logic [ADDR_WIDTH-1:0] bpu_redirect_pc_o,
    output logic                  frontend_stall_o,
`ifdef FTQ_REDIRECT_PERF_EN
    output logic                  busy_o,
    output logic [31:0]           perf_backend_flush_cnt_o,
    output logic [31:0]           perf_ifu_flush_cnt_o,
    output logic [31:0]           perf_ifu_drop_cnt_o,
    output logic [31:0]           perf_stall_cycles_o
`else
    output logic                  busy_o
`endif
);

    // Recovery counter is 4 bits wide: RECOVER_CYCLES is limited to 1..15.
    localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    redirect_state_e       state_q, state_d;
    logic [3:0]            cnt_q,   cnt_d;
    redirect_src_e         src_q,   src_d;
    logic [PTR_W-1:0]      id_q,    id_d;
    logic [ADDR_WIDTH-1:0] pc_q,    pc_d;

    // ------------------------------------------------------------------
    // Candidate selection
    // ------------------------------------------------------------------
    logic backend_older;
    logic ifu_cand;
    logic backend_wins;
    logic ifu_wins;

    // Backend sits on port a so an equal-age tie goes to the backend.
    ftq_age_compare #(
        .PTR_W (PTR_W)
    ) u_age_compare (
        .comm_ptr_i   (comm_ptr_i),
        .id_a_i       (backend_flush_ftq_id_i),
        .id_b_i       (ifu_flush_ftq_id_i),
        .older_is_a_o (backend_older)
    );

    // Once a flush is in flight the IFU's block lies on a squashed path,
    // so its requests only count while the sequencer is idle.
    assign ifu_cand     = ifu_flush_valid_i && (state_q == IDLE);
    assign backend_wins = backend_flush_valid_i && (!ifu_cand || backend_older);
    assign ifu_wins     = ifu_cand && !backend_wins;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        id_d    = id_q;
        pc_d    = pc_q;

        if (backend_wins) begin
            // A backend redirect is authoritative even mid-recovery: no age
            // check against the flush already in progress, window restarts.
            state_d = FLUSH;
            src_d   = SRC_BACKEND;
            id_d    = backend_flush_ftq_id_i;
            pc_d    = backend_flush_target_i;
        end else if (ifu_wins) begin
            state_d = FLUSH;
            src_d   = SRC_IFU;
            id_d    = ifu_flush_ftq_id_i;
            pc_d    = ifu_flush_target_i;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                FLUSH: begin
                    state_d = RECOVER;
                    cnt_d   = RECOVER_LOAD;
                end
                RECOVER: begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            src_q   <= SRC_BACKEND;
            id_q    <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            id_q    <= id_d;
            pc_q    <= pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registers, so the pulse is glitch-free and
    // exactly one cycle long (FLUSH never persists without a new request).
    // ------------------------------------------------------------------
    assign ftq_backend_flush_o  = (state_q == FLUSH) && (src_q == SRC_BACKEND);
    assign ftq_ifu_flush_o      = (state_q == FLUSH) && (src_q == SRC_IFU);
    assign bpu_redirect_valid_o = (state_q == FLUSH);
    assign ftq_flush_ftq_id_o   = id_q;
    assign bpu_redirect_pc_o    = pc_q;
    assign frontend_stall_o     = (state_q != IDLE);
    assign busy_o               = (state_q != IDLE);

`ifdef FTQ_REDIRECT_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------
    logic        ifu_drop;
    logic [31:0] perf_bk_q, perf_ifu_q, perf_drop_q, perf_stall_q;

    // Dropped = presented but not selected, whether it lost arbitration
    // or arrived while a flush was in flight.
    assign ifu_drop = ifu_flush_valid_i && !ifu_wins;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_bk_q    <= '0;
            perf_ifu_q   <= '0;
            perf_drop_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (ftq_backend_flush_o && (perf_bk_q != '1)) begin
                perf_bk_q <= perf_bk_q + 32'd1;
            end
            if (ftq_ifu_flush_o && (perf_ifu_q != '1)) begin
                perf_ifu_q <= perf_ifu_q + 32'd1;
            end
            if (ifu_drop && (perf_drop_q != '1)) begin
                perf_drop_q <= perf_drop_q + 32'd1;
            end
            if (frontend_stall_o && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_backend_flush_cnt_o = perf_bk_q;
    assign perf_ifu_flush_cnt_o     = perf_ifu_q;
    assign perf_ifu_drop_cnt_o      = perf_drop_q;
    assign perf_stall_cycles_o      = perf_stall_q;
`endif

endmodule : ftq_redirect_ctrl
